// File: rtl/sram_controller.sv
// Memory-stage bridge onto a 16-bit asynchronous SRAM: each 32-bit access is split into a low then high half-word phase.
// Optional `define SRAM_WAIT_EN stretches every phase by WAIT_CYCLES extra cycles.
module sram_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic [16:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] rd_lo_q, rd_lo_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] eff;
    logic        req;
    logic        phase_done;
    logic        drive;
    logic [15:0] dq_out;
    logic        unused_eff;

    assign eff        = address - BASE_ADDR;
    assign unused_eff = ^{eff[31:19], eff[1:0]};
    assign req        = wr_en | rd_en;

`ifdef SRAM_WAIT_EN
    logic [2:0] cnt_q, cnt_d;
    logic       phase_load;

    // Reload whenever a phase is entered so every phase gets the full wait.
    assign phase_load = (state_d != state_q) && ((state_d == S_LO) || (state_d == S_HI));
    assign phase_done = (cnt_q == 3'd0);

    always_comb begin
        cnt_d = cnt_q;
        if (phase_load) begin
            cnt_d = 3'(WAIT_CYCLES);
        end else if (((state_q == S_LO) || (state_q == S_HI)) && (cnt_q != 3'd0)) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    localparam int unsigned unused_wait_cycles = WAIT_CYCLES;
    assign phase_done = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_lo_d = rd_lo_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_LO;
                    is_wr_d = wr_en;
                    addr_d  = eff[18:2];
                    wdata_d = write_data;
                end
            end
            S_LO: begin
                if (phase_done) begin
                    state_d = S_HI;
                    if (!is_wr_q) begin
                        rd_lo_d = SRAM_DQ;
                    end
                end
            end
            S_HI: begin
                if (phase_done) begin
                    state_d = S_DONE;
                    // Commit both halves together so read_data never shows a half-updated word.
                    if (!is_wr_q) begin
                        rdata_d = {SRAM_DQ, rd_lo_q};
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            is_wr_q <= 1'b0;
            addr_q  <= 17'd0;
            wdata_q <= 32'd0;
            rd_lo_q <= 16'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_lo_q <= rd_lo_d;
            rdata_q <= rdata_d;
        end
    end

    assign ready = (state_q == S_DONE) || ((state_q == S_IDLE) && !req);

    assign drive  = is_wr_q && ((state_q == S_LO) || (state_q == S_HI));
    assign dq_out = (state_q == S_HI) ? wdata_q[31:16] : wdata_q[15:0];

    assign SRAM_DQ   = drive ? dq_out : 16'hzzzz;
    assign SRAM_WE_N = ~drive;
    assign SRAM_ADDR = {addr_q, (state_q == S_HI)};
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
    assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: behavioural SRAM device plus a word-level reference model.
module tb_sram_controller;

    localparam logic [31:0] BASE = 32'd1024;
    localparam int W = 2;
`ifdef SRAM_WAIT_EN
    localparam int EW = W;
`else
    localparam int EW = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;

    sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data),
        .read_data(read_data), .ready(ready),
        .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM device: outputs whenever not being written.
    logic [15:0] sram [0:262143];
    assign SRAM_DQ = SRAM_WE_N ? sram[SRAM_ADDR] : 16'hzzzz;
    always @(posedge clk) if (!SRAM_WE_N) sram[SRAM_ADDR] = SRAM_DQ;

    // Reference model: 32-bit words keyed by word index, plus last read result.
    logic [31:0] ref_mem [int];
    logic [31:0] rd_last;
    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int word_idx(input logic [31:0] a);
        logic [31:0] e;
        e = a - BASE;
        return int'((e >> 2) % 32'd131072);
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic hold);
        int idx, cyc, cnt;
        logic hi, seen;
        logic [31:0] lo_a;
        idx  = word_idx(a);
        lo_a = 32'(idx) * 2;
        wr_en = w; rd_en = r; address = a; write_data = d;
        #1 check("ready_req", {31'd0, ready}, 32'd0);
        seen = 1'b0;
        for (cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (ready) begin seen = 1'b1; break; end
            if (!hold) begin address = $urandom; write_data = $urandom; end
            hi = (cyc > EW + 1);
            check("sram_addr", {14'd0, SRAM_ADDR}, lo_a + {31'd0, hi});
            check("we_n", {31'd0, SRAM_WE_N}, {31'd0, !w});
            if (w) check("dq", {16'd0, SRAM_DQ}, {16'd0, hi ? d[31:16] : d[15:0]});
        end
        check("latency", cyc, 3 + 2 * EW);
        if (w) ref_mem[idx] = d;
        else rd_last = ref_mem.exists(idx) ? ref_mem[idx] : 32'd0;
        check("rdata", read_data, rd_last);
        if (hold && seen) begin
            // Request still high in DONE: one IDLE cycle must precede the next access.
            for (cnt = 1; cnt <= 40; cnt++) begin
                @(negedge clk);
                if (cnt == 1) check("hold_idle_ready", {31'd0, ready}, 32'd0);
                if (cnt == 2) rd_en = 1'b0;
                if (ready && cnt > 1) break;
            end
            check("hold_latency", cnt, 4 + 2 * EW);
            check("hold_rdata", read_data, rd_last);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        check("idle_ready", {31'd0, ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] a, d;
        int idx, op;
        for (int i = 0; i < 262144; i++) sram[i] = 16'h0000;
        rd_last = 32'd0;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
        @(negedge clk);
        check("rst_rdata", read_data, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check("strobes", {28'd0, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, ready}, 32'd1);

        access(1'b1, 1'b0, 32'd1024, 32'h12345678, 1'b0);
        check("hw0", {16'd0, sram[0]}, 32'h5678);
        check("hw1", {16'd0, sram[1]}, 32'h1234);
        access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
        check("read_1024", read_data, 32'h12345678);
        access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0);
        access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
        check("read_1028", read_data, 32'hDEADBEEF);
        access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 1'b0);
        check("both_rdata_kept", read_data, 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);
        check("read_1032", read_data, 32'hCAFEF00D);
        access(1'b1, 1'b0, BASE - 32'd4, 32'hA5A55A5A, 1'b0);
        access(1'b0, 1'b1, BASE - 32'd4, 32'h0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 15);
            a = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3)) + (32'($urandom_range(0, 8191)) << 19);
            d = $urandom;
            op = $urandom_range(0, 3);
            if (op <= 1) access(1'b1, 1'b0, a, d, 1'b0);
            else if (op == 2) access(1'b0, 1'b1, a, d, ($urandom_range(0, 3) == 0));
            else access(1'b1, 1'b1, a, d, 1'b0);
        end

        // Reset during the high phase of a write to a word nothing reads later.
        access(1'b1, 1'b0, BASE + 32'd12, 32'h0BADF00D, 1'b0);
        access(1'b0, 1'b1, BASE + 32'd12, 32'h0, 1'b0);
        wr_en = 1'b1; address = BASE + 32'd20000; write_data = 32'h55AA33CC;
        repeat (EW + 2) @(negedge clk);
        check("pre_rst_we_n", {31'd0, SRAM_WE_N}, 32'd0);
        check("pre_rst_addr", {14'd0, SRAM_ADDR}, 32'd10001);
        rst = 1'b1;
        #1 check("mid_rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check("mid_rst_rdata", read_data, 32'd0);
        check("mid_rst_dq", {16'd0, SRAM_DQ}, {16'd0, sram[SRAM_ADDR]});
        wr_en = 1'b0;
        #1 check("mid_rst_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        rd_last = 32'd0;
        ref_mem.delete(word_idx(BASE + 32'd20000));
        @(negedge clk);
        check("after_rst_ready", {31'd0, ready}, 32'd1);
        check("after_rst_rdata", read_data, 32'd0);
        access(1'b0, 1'b1, BASE + 32'd12, 32'h0, 1'b0);
        check("read_after_rst", read_data, 32'h0BADF00D);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
